// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered read ports, one write port, optional
// write-to-read bypass, optional hardwired zero register, a per-entry busy
// scoreboard and a post-reset clear sweep that zeroes every entry.
module regfile_2r1w_sb #(
   parameter int ADDRESS_LEN = 4,
   parameter int DATA_LEN    = 16,
   parameter int ZERO_REG    = 1,
   parameter int BYPASS      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDRESS_LEN-1:0] rd0_addr,
   input  logic [ADDRESS_LEN-1:0] rd1_addr,
   output logic [DATA_LEN-1:0]    rd0_data,
   output logic [DATA_LEN-1:0]    rd1_data,
   output logic                   rd0_busy,
   output logic                   rd1_busy,
   input  logic                   wr_en,
   input  logic [ADDRESS_LEN-1:0] wr_addr,
   input  logic [DATA_LEN-1:0]    wr_data,
   input  logic                   busy_set,
   input  logic [ADDRESS_LEN-1:0] busy_addr,
   output logic                   init_done
);

   localparam int DEPTH = 2 ** ADDRESS_LEN;
   localparam int CNT_W = ADDRESS_LEN + 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                                state_q, state_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d, cnt_next;
   logic [DEPTH-1:0]                      busy_q, busy_d;
   logic [DATA_LEN-1:0]                   mem_q [DEPTH];
   logic [DATA_LEN-1:0]                   mem_d [DEPTH];
   logic [1:0][DATA_LEN-1:0]              rd_data_q, rd_data_d;
   logic [1:0]                            rd_busy_q, rd_busy_d;
   logic                                  init_done_q, init_done_d;
   logic [1:0][ADDRESS_LEN-1:0]           rd_addr;
   logic                                  wr_eff;
   logic                                  set_eff;

   // True when the address names the hardwired zero entry.
   function automatic logic is_zero_reg(input logic [ADDRESS_LEN-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   assign rd_addr[0] = rd0_addr;
   assign rd_addr[1] = rd1_addr;

   // Qualified write/busy-set requests: ignored during the sweep and on r0.
   always_comb begin
      wr_eff  = (state_q == ST_READY) && wr_en    && !is_zero_reg(wr_addr);
      set_eff = (state_q == ST_READY) && busy_set && !is_zero_reg(busy_addr);
   end

   // Sweep sequencing: the counter carries one spare bit so terminal count
   // shows up as the MSB of the incremented value instead of a wrap to 0.
   always_comb begin
      cnt_next    = cnt_q + CNT_W'(1);
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_next;
         if (cnt_next[ADDRESS_LEN]) begin
            state_d     = ST_READY;
            init_done_d = 1'b1;
         end
      end
   end

   // Scoreboard update: a write retires its entry, a new issue re-marks it;
   // issue is applied last so it wins on a same-address collision.
   always_comb begin
      busy_d = busy_q;
      if (state_q == ST_CLEAR) begin
         busy_d = '0;
      end else begin
         if (wr_eff)  busy_d[wr_addr]   = 1'b0;
         if (set_eff) busy_d[busy_addr] = 1'b1;
      end
   end

   // Storage update: the sweep zeroes one entry per cycle, then normal writes.
   always_comb begin
      mem_d = mem_q;
      if (state_q == ST_CLEAR) begin
         mem_d[cnt_q[ADDRESS_LEN-1:0]] = '0;
      end else if (wr_eff) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Read ports: array lookup with optional same-cycle forwarding of the
   // write data and of the busy set/clear; outputs held at 0 during the sweep.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data_d[p] = '0;
         rd_busy_d[p] = 1'b0;
         if ((state_q == ST_READY) && !is_zero_reg(rd_addr[p])) begin
            rd_data_d[p] = mem_q[rd_addr[p]];
            rd_busy_d[p] = busy_q[rd_addr[p]];
            if (BYPASS != 0) begin
               if (wr_eff && (wr_addr == rd_addr[p])) begin
                  rd_data_d[p] = wr_data;
                  rd_busy_d[p] = 1'b0;
               end
               if (set_eff && (busy_addr == rd_addr[p])) begin
                  rd_busy_d[p] = 1'b1;
               end
            end
         end
      end
   end

   // Control and read-output registers; reset restarts the clear sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         busy_q      <= '0;
         rd_data_q   <= '0;
         rd_busy_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         rd_data_q   <= rd_data_d;
         rd_busy_q   <= rd_busy_d;
         init_done_q <= init_done_d;
      end
   end

   // Entry storage; not reset, the sweep brings it to a known state.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd0_data  = rd_data_q[0];
   assign rd1_data  = rd_data_q[1];
   assign rd0_busy  = rd_busy_q[0];
   assign rd1_busy  = rd_busy_q[1];
   assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb: one bypassing instance and one
// non-bypassing instance share the same stimulus.
module tb_regfile_2r1w_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rd0_addr, rd1_addr, wr_addr, busy_addr;
   logic [15:0] wr_data;
   logic        wr_en, busy_set;

   logic [15:0] rd0_data, rd1_data, nb_rd0_data, nb_rd1_data;
   logic        rd0_busy, rd1_busy, nb_rd0_busy, nb_rd1_busy;
   logic        init_done, nb_init_done;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   regfile_2r1w_sb #(.ADDRESS_LEN(4), .DATA_LEN(16), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
      .rd0_data(rd0_data), .rd1_data(rd1_data),
      .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set(busy_set), .busy_addr(busy_addr),
      .init_done(init_done)
   );

   regfile_2r1w_sb #(.ADDRESS_LEN(4), .DATA_LEN(16), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
      .rd0_data(nb_rd0_data), .rd1_data(nb_rd1_data),
      .rd0_busy(nb_rd0_busy), .rd1_busy(nb_rd1_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set(busy_set), .busy_addr(busy_addr),
      .init_done(nb_init_done)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%04h exp=0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      busy_set = 1'b0; busy_addr = '0;
   endtask

   initial begin
      rst = 1'b1; rd0_addr = '0; rd1_addr = '0;
      idle_inputs();
      step();
      step();
      chk("rst_rd0_data", rd0_data, 16'h0000);
      chk("rst_rd1_busy", 16'(rd1_busy), 16'h0);
      chk("rst_init_done", 16'(init_done), 16'h0);

      // Sweep after reset: init_done first high on the 16th edge.
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk($sformatf("sweep_init_done_%0d", i), 16'(init_done), (i == 16) ? 16'h1 : 16'h0);
      end
      chk("sweep_nb_init_done", 16'(nb_init_done), 16'h1);

      // Every entry reads 0, not busy.
      for (int a = 0; a < 16; a++) begin
         rd0_addr = 4'(a); rd1_addr = 4'(15 - a);
         step();
         chk($sformatf("clr_rd0_%0d", a), rd0_data, 16'h0000);
         chk($sformatf("clr_rd1_%0d", 15 - a), rd1_data, 16'h0000);
         chk($sformatf("clr_busy0_%0d", a), 16'(rd0_busy), 16'h0);
      end

      // Write r5 then read it on both ports.
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
      rd0_addr = 4'd0; rd1_addr = 4'd0;
      step();
      idle_inputs();
      rd0_addr = 4'd5; rd1_addr = 4'd5;
      step();
      chk("r5_rd0", rd0_data, 16'hBEEF);
      chk("r5_rd1", rd1_data, 16'hBEEF);
      chk("r5_nb_rd0", nb_rd0_data, 16'hBEEF);

      // Same-cycle write and read of r7.
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
      rd0_addr = 4'd7; rd1_addr = 4'd5;
      step();
      chk("byp_r7", rd0_data, 16'h1234);
      chk("nobyp_r7_old", nb_rd0_data, 16'h0000);
      chk("byp_r5_other_port", rd1_data, 16'hBEEF);
      idle_inputs();
      step();
      chk("nobyp_r7_new", nb_rd0_data, 16'h1234);

      // Scoreboard: set r3 while reading it.
      busy_set = 1'b1; busy_addr = 4'd3;
      rd0_addr = 4'd3; rd1_addr = 4'd3;
      step();
      chk("set_byp_busy", 16'(rd0_busy), 16'h1);
      chk("set_nobyp_busy_old", 16'(nb_rd0_busy), 16'h0);
      idle_inputs();
      step();
      chk("r3_busy_rd0", 16'(rd0_busy), 16'h1);
      chk("r3_busy_rd1", 16'(rd1_busy), 16'h1);
      chk("r3_nb_busy", 16'(nb_rd1_busy), 16'h1);

      // Result write retires r3.
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
      step();
      chk("wr3_byp_data", rd0_data, 16'h00AA);
      chk("wr3_byp_busy", 16'(rd0_busy), 16'h0);
      chk("wr3_nb_data_old", nb_rd0_data, 16'h0000);
      chk("wr3_nb_busy_old", 16'(nb_rd0_busy), 16'h1);
      idle_inputs();
      step();
      chk("r3_data", rd0_data, 16'h00AA);
      chk("r3_busy_clr", 16'(rd0_busy), 16'h0);
      chk("r3_nb_busy_clr", 16'(nb_rd0_busy), 16'h0);

      // Set and write r3 together: set wins.
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h0055;
      busy_set = 1'b1; busy_addr = 4'd3;
      step();
      chk("coll_byp_data", rd0_data, 16'h0055);
      chk("coll_byp_busy", 16'(rd0_busy), 16'h1);
      chk("coll_nb_data_old", nb_rd0_data, 16'h00AA);
      chk("coll_nb_busy_old", 16'(nb_rd0_busy), 16'h0);
      idle_inputs();
      step();
      chk("coll_busy", 16'(rd0_busy), 16'h1);
      chk("coll_nb_busy", 16'(nb_rd1_busy), 16'h1);
      chk("coll_data", rd1_data, 16'h0055);

      // Zero register ignores writes and busy marks, even with bypass.
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      busy_set = 1'b1; busy_addr = 4'd0;
      rd0_addr = 4'd0; rd1_addr = 4'd0;
      step();
      chk("r0_byp_data", rd0_data, 16'h0000);
      chk("r0_byp_busy", 16'(rd0_busy), 16'h0);
      idle_inputs();
      step();
      chk("r0_data", rd1_data, 16'h0000);
      chk("r0_busy", 16'(rd1_busy), 16'h0);
      chk("r0_nb_data", nb_rd0_data, 16'h0000);

      // Reset in READY after r2 = 0x5555.
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
      step();
      idle_inputs();
      rd0_addr = 4'd2; rd1_addr = 4'd3;
      step();
      chk("r2_before_rst", rd0_data, 16'h5555);
      rst = 1'b1;
      step();
      chk("rst_ready_init_done", 16'(init_done), 16'h0);
      chk("rst_ready_rd0", rd0_data, 16'h0000);
      rst = 1'b0;

      // Writes and busy marks during the sweep are dropped; reset at count 9.
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777;
      busy_set = 1'b1; busy_addr = 4'd4;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk($sformatf("clr1_rd0_%0d", i), rd0_data, 16'h0000);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      wr_addr = 4'd9; wr_data = 16'h9999;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk($sformatf("clr2_init_done_%0d", i), 16'(init_done), (i == 16) ? 16'h1 : 16'h0);
      end
      idle_inputs();

      rd0_addr = 4'd2; rd1_addr = 4'd3;
      step();
      chk("post_r2_data", rd0_data, 16'h0000);
      chk("post_r3_busy", 16'(rd1_busy), 16'h0);
      chk("post_r3_data", rd1_data, 16'h0000);
      rd0_addr = 4'd4; rd1_addr = 4'd9;
      step();
      chk("post_r4_busy", 16'(rd0_busy), 16'h0);
      chk("post_r9_data", rd1_data, 16'h0000);
      chk("post_nb_r9_data", nb_rd1_data, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
